// File: rtl/io_port_bridge.sv
// Memory-mapped I/O bridge: data/status registers over a TX and an RX FIFO.
// Define IO_BRIDGE_LOOPBACK_EN to route TX into RX and disconnect the streams.
module io_port_bridge #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] DATA_ADDR = 32'hFFFF_FFFC,
    parameter logic [31:0] STAT_ADDR = 32'hFFFF_FFF8
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   tx_mem_d [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d;
    logic [AW-1:0] tx_rp_q, tx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    logic [31:0]   rx_mem_q [DEPTH];
    logic [31:0]   rx_mem_d [DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d;
    logic [AW-1:0] rx_rp_q, rx_rp_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    logic tx_ovf_q, tx_ovf_d;
    logic rx_unf_q, rx_unf_d;

    logic        data_hit, stat_hit;
    logic        data_rd, data_wr, stat_wr;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] tx_head, rx_head, rx_push_data;
    logic [31:0] stat_word;

    always_comb begin
        data_hit = (io_addr == DATA_ADDR);
        stat_hit = (io_addr == STAT_ADDR);
        data_rd  = io_re & data_hit;
        data_wr  = io_we & data_hit;
        stat_wr  = io_we & stat_hit;

        tx_empty = (tx_cnt_q == '0);
        tx_full  = (tx_cnt_q == FULL_CNT);
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL_CNT);

        tx_head  = tx_mem_q[tx_rp_q];
        rx_head  = rx_mem_q[rx_rp_q];
    end

`ifdef IO_BRIDGE_LOOPBACK_EN
    logic lb_move;
    logic unused_stream;

    assign unused_stream = ^{tx_ready, rx_valid, rx_data};
    // The TX head hops into RX whenever there is room on the RX side.
    assign lb_move      = ~tx_empty & ~rx_full;
    assign tx_pop       = lb_move;
    assign rx_push      = lb_move;
    assign rx_push_data = tx_head;
    assign tx_valid     = 1'b0;
    assign rx_ready     = 1'b0;
`else
    assign tx_valid     = ~tx_empty;
    assign rx_ready     = Reset_n & ~rx_full;
    assign tx_pop       = tx_valid & tx_ready;
    assign rx_push      = rx_valid & rx_ready;
    assign rx_push_data = rx_data;
`endif

    assign tx_push = data_wr & ~tx_full;
    assign rx_pop  = data_rd & ~rx_empty;
    assign tx_data = tx_empty ? 32'h0 : tx_head;

    always_comb begin
        stat_word       = 32'h0;
        stat_word[0]    = ~rx_empty;
        stat_word[1]    = ~tx_full;
        stat_word[2]    = tx_ovf_q;
        stat_word[3]    = rx_unf_q;
        stat_word[15:8] = 8'(rx_cnt_q);
    end

    always_comb begin
        io_rdata = 32'h0;
        if (Reset_n && io_re) begin
            if (data_hit) begin
                io_rdata = rx_empty ? 32'h0 : rx_head;
            end else if (stat_hit) begin
                io_rdata = stat_word;
            end
        end
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = io_wdata;
            tx_wp_d           = tx_wp_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rp_d = tx_rp_q + 1'b1;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_push_data;
            rx_wp_d           = rx_wp_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rp_d = rx_rp_q + 1'b1;
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // A new error event outranks a same-cycle write-1-to-clear.
    always_comb begin
        tx_ovf_d = (tx_ovf_q & ~(stat_wr & io_wdata[2])) | (data_wr & tx_full);
        rx_unf_d = (rx_unf_q & ~(stat_wr & io_wdata[3])) | (data_rd & rx_empty);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_mem_q <= '{default: '0};
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_mem_q <= '{default: '0};
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_mem_q <= tx_mem_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_mem_q <= rx_mem_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

endmodule
